// File: rtl/calc_n_if.sv
// calc_n_if: request/response bundle for calc_n.
//   req_cmd_in  [NPORTS*4]       per-port command, port p at [4p +: 4]
//   req_data_in [NPORTS*DATA_W]  op1 on the command cycle, op2 on the next
//   req_tag_in  [NPORTS*TAG_W]   tag, sampled on the command cycle
//   out_resp    [NPORTS*2]       0 none, 1 success, 2 error (one-cycle pulse)
//   out_data    [NPORTS*DATA_W]  result, 0 unless out_resp = 1
//   out_tag     [NPORTS*TAG_W]   tag of the responding request
//   out_busy    [NPORTS]         port cannot accept a new command this cycle
interface calc_n_if #(
  parameter int NPORTS = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
);
  logic [NPORTS*4-1:0]      req_cmd_in;
  logic [NPORTS*DATA_W-1:0] req_data_in;
  logic [NPORTS*TAG_W-1:0]  req_tag_in;
  logic [NPORTS*2-1:0]      out_resp;
  logic [NPORTS*DATA_W-1:0] out_data;
  logic [NPORTS*TAG_W-1:0]  out_tag;
  logic [NPORTS-1:0]        out_busy;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  out_resp, out_data, out_tag, out_busy
  );
  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output out_resp, out_data, out_tag, out_busy
  );
endinterface

// File: rtl/calc_n.sv
// calc_n: NPORTS-port add/sub/shift engine with one shared ALU.
// Each port runs a two-cycle capture FSM (cmd+op1, then op2) that feeds a
// DEPTH-entry FIFO. A round-robin arbiter picks one nonempty FIFO per cycle;
// the ALU result is registered and shown on the granted port's outputs for
// exactly one cycle.
//   c_clk   clock, rising edge
//   reset   asynchronous, active low
//   bus     calc_n_if slave modport (request inputs, response/busy outputs)
// DATA_W must be >= 2 (shift amount needs at least one bit).

// Per-port capture FSM and request FIFO.
//   cmd/data/tag   port request inputs
//   deq            arbiter grant: pop the head entry this edge
//   busy           no room for another command (counts the one in OP2)
//   nonempty       FIFO holds at least one entry
//   h_*            head entry fields
module calc_n_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag,
  input  logic              deq,
  output logic              busy,
  output logic              nonempty,
  output logic [3:0]        h_cmd,
  output logic [DATA_W-1:0] h_op1,
  output logic [DATA_W-1:0] h_op2,
  output logic [TAG_W-1:0]  h_tag
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OP2  = 1'b1;

  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  logic [0:0]    state;
  ent_t          cap;
  ent_t          wr;
  ent_t          mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [OW-1:0] occ;
  logic          enq;

  // The OP2 cycle always enqueues; its slot was reserved by busy on entry.
  assign enq      = (state == OP2);
  assign occ      = {1'b0, cnt} + OW'(enq);
  assign busy     = occ >= OW'(DEPTH);
  assign nonempty = (cnt != '0);

  always_comb begin
    wr     = cap;
    wr.op2 = data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cap   <= '0;
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (cmd != 4'd0 && !busy) begin
          cap.cmd <= cmd;
          cap.op1 <= data;
          cap.tag <= tag;
          state   <= OP2;
        end
        default: state <= IDLE;
      endcase
      if (enq) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (enq) mem[wp] <= wr;
  end

  ent_t head;
  assign head  = mem[rp];
  assign h_cmd = head.cmd;
  assign h_op1 = head.op1;
  assign h_op2 = head.op2;
  assign h_tag = head.tag;
endmodule

module calc_n #(
  parameter int NPORTS   = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 2,
  parameter int SATURATE = 0
) (
  input  logic     c_clk,
  input  logic     reset,
  calc_n_if.slave  bus
);
  localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int SW  = PW + 1;
  localparam int SHW = $clog2(DATA_W);

  typedef struct packed {
    logic [1:0]        resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rsp_t;

  logic [NPORTS-1:0]             busy, nonempty, deq;
  logic [NPORTS-1:0][3:0]        h_cmd;
  logic [NPORTS-1:0][DATA_W-1:0] h_op1, h_op2;
  logic [NPORTS-1:0][TAG_W-1:0]  h_tag;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    calc_n_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_port (
      .clk      (c_clk),
      .rst_n    (reset),
      .cmd      (bus.req_cmd_in[4*p +: 4]),
      .data     (bus.req_data_in[DATA_W*p +: DATA_W]),
      .tag      (bus.req_tag_in[TAG_W*p +: TAG_W]),
      .deq      (deq[p]),
      .busy     (busy[p]),
      .nonempty (nonempty[p]),
      .h_cmd    (h_cmd[p]),
      .h_op1    (h_op1[p]),
      .h_op2    (h_op2[p]),
      .h_tag    (h_tag[p])
    );
  end

  // Round-robin: scan rr, rr+1, ... with wrap. Walking the offsets from the
  // far end down lets the nearest nonempty port overwrite the others.
  logic [PW-1:0] rr, gnt_idx;
  logic          gnt_vld;
  logic [SW-1:0] s;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    s       = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      s = {1'b0, rr} + SW'(i);
      if (s >= SW'(NPORTS)) s = s - SW'(NPORTS);
      if (nonempty[s[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = s[PW-1:0];
      end
    end
  end

  always_comb begin
    deq = '0;
    for (int p = 0; p < NPORTS; p++)
      deq[p] = gnt_vld && (gnt_idx == PW'(p));
  end

  // Shared ALU on the granted head entry.
  logic [3:0]        a_cmd;
  logic [DATA_W-1:0] a_op1, a_op2;
  logic [DATA_W:0]   a_sum;
  logic [SHW-1:0]    a_sh;
  rsp_t              a_rsp;

  assign a_cmd = h_cmd[gnt_idx];
  assign a_op1 = h_op1[gnt_idx];
  assign a_op2 = h_op2[gnt_idx];
  assign a_sum = {1'b0, a_op1} + {1'b0, a_op2};
  assign a_sh  = a_op2[SHW-1:0];

  always_comb begin
    a_rsp.resp = 2'd2;
    a_rsp.data = '0;
    a_rsp.tag  = h_tag[gnt_idx];
    case (a_cmd)
      4'd1: begin
        if (!a_sum[DATA_W]) begin
          a_rsp.resp = 2'd1;
          a_rsp.data = a_sum[DATA_W-1:0];
        end else if (SATURATE != 0) begin
          a_rsp.resp = 2'd1;
          a_rsp.data = '1;
        end
      end
      4'd2: begin
        if (a_op2 <= a_op1) begin
          a_rsp.resp = 2'd1;
          a_rsp.data = a_op1 - a_op2;
        end else if (SATURATE != 0) begin
          a_rsp.resp = 2'd1;
        end
      end
      4'd5: begin
        a_rsp.resp = 2'd1;
        a_rsp.data = a_op1 << a_sh;
      end
      4'd6: begin
        a_rsp.resp = 2'd1;
        a_rsp.data = a_op1 >> a_sh;
      end
      default: ;
    endcase
  end

  // Single result register; outputs are decoded from it so only the
  // granted port is ever nonzero and reset blanks everything at once.
  logic          res_vld;
  logic [PW-1:0] res_port;
  rsp_t          res;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr       <= '0;
      res_vld  <= 1'b0;
      res_port <= '0;
      res      <= '0;
    end else begin
      res_vld <= gnt_vld;
      if (gnt_vld) begin
        res_port <= gnt_idx;
        res      <= a_rsp;
        rr       <= (gnt_idx == PW'(NPORTS - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  logic [NPORTS-1:0][1:0]        o_resp;
  logic [NPORTS-1:0][DATA_W-1:0] o_data;
  logic [NPORTS-1:0][TAG_W-1:0]  o_tag;

  always_comb begin
    o_resp = '0;
    o_data = '0;
    o_tag  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (res_vld && res_port == PW'(p)) begin
        o_resp[p] = res.resp;
        o_data[p] = res.data;
        o_tag[p]  = res.tag;
      end
    end
  end

  assign bus.out_resp = o_resp;
  assign bus.out_data = o_data;
  assign bus.out_tag  = o_tag;
  assign bus.out_busy = busy;
endmodule

// File: tb/tb_calc_n.sv
// tb_calc_n: drives one stimulus stream into two calc_n instances
// (SATURATE=0 and SATURATE=1) and checks both every cycle against a
// queue-based reference model, plus hand-computed literal results.
module tb_calc_n;
  localparam int NP = 4, DW = 32, DEP = 4, TW = 2;

  logic c_clk = 1'b0;
  logic reset = 1'b0;
  always #5 c_clk = ~c_clk;

  logic [NP*4-1:0]  cmd_v;
  logic [NP*DW-1:0] data_v;
  logic [NP*TW-1:0] tag_v;

  calc_n_if #(.NPORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus0 ();
  calc_n_if #(.NPORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus1 ();

  assign bus0.req_cmd_in  = cmd_v;
  assign bus0.req_data_in = data_v;
  assign bus0.req_tag_in  = tag_v;
  assign bus1.req_cmd_in  = cmd_v;
  assign bus1.req_data_in = data_v;
  assign bus1.req_tag_in  = tag_v;

  calc_n #(.NPORTS(NP), .DATA_W(DW), .DEPTH(DEP), .TAG_W(TW), .SATURATE(0))
    dut0 (.c_clk(c_clk), .reset(reset), .bus(bus0));
  calc_n #(.NPORTS(NP), .DATA_W(DW), .DEPTH(DEP), .TAG_W(TW), .SATURATE(1))
    dut1 (.c_clk(c_clk), .reset(reset), .bus(bus1));

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } ent_t;

  ent_t        mq   [NP][$];
  ent_t        pend [NP];
  bit          ph   [NP];
  int          rr;
  logic [1:0]  e_resp [2][NP];
  logic [31:0] e_data [2][NP];
  logic [1:0]  e_tag  [2][NP];

  function automatic void clear_out();
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < NP; p++) begin
        e_resp[s][p] = 2'd0;
        e_data[s][p] = 32'd0;
        e_tag[s][p]  = 2'd0;
      end
  endfunction

  function automatic void model_clear();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      ph[p] = 1'b0;
    end
    rr = 0;
    clear_out();
  endfunction

  function automatic void alu(input ent_t e, input bit sat,
                              output logic [1:0] r, output logic [31:0] d);
    longint a = longint'(e.op1);
    longint b = longint'(e.op2);
    r = 2'd1;
    d = 32'd0;
    case (e.cmd)
      4'd1: if (a + b > 64'hFFFF_FFFF) begin
              if (sat) d = 32'hFFFF_FFFF; else r = 2'd2;
            end else d = 32'(a + b);
      4'd2: if (b > a) begin
              if (!sat) r = 2'd2;
            end else d = 32'(a - b);
      4'd5: d = 32'(a << (b % 32));
      4'd6: d = 32'(a >> (b % 32));
      default: r = 2'd2;
    endcase
  endfunction

  function automatic bit m_busy(input int p);
    return (mq[p].size() + int'(ph[p])) >= DEP;
  endfunction

  always @(posedge c_clk) begin : model_step
    bit   bz [NP];
    int   g;
    ent_t e;
    if (reset) begin
      for (int p = 0; p < NP; p++) bz[p] = m_busy(p);
      clear_out();
      g = -1;
      for (int i = 0; i < NP; i++)
        if (g < 0 && mq[(rr + i) % NP].size() > 0) g = (rr + i) % NP;
      if (g >= 0) begin
        e = mq[g].pop_front();
        for (int s = 0; s < 2; s++) begin
          alu(e, s[0], e_resp[s][g], e_data[s][g]);
          e_tag[s][g] = e.tag;
        end
        rr = (g + 1) % NP;
      end
      for (int p = 0; p < NP; p++) begin
        if (ph[p]) begin
          pend[p].op2 = data_v[32*p +: 32];
          mq[p].push_back(pend[p]);
          ph[p] = 1'b0;
        end else if (cmd_v[4*p +: 4] != 4'd0 && !bz[p]) begin
          pend[p].cmd = cmd_v[4*p +: 4];
          pend[p].op1 = data_v[32*p +: 32];
          pend[p].tag = tag_v[2*p +: 2];
          ph[p] = 1'b1;
        end
      end
    end
  end

  always @(negedge reset) model_clear();

  function automatic logic [36:0] dut_out(input int s, input int p);
    if (s == 0)
      return {bus0.out_resp[2*p +: 2], bus0.out_data[32*p +: 32],
              bus0.out_tag[2*p +: 2], bus0.out_busy[p]};
    return {bus1.out_resp[2*p +: 2], bus1.out_data[32*p +: 32],
            bus1.out_tag[2*p +: 2], bus1.out_busy[p]};
  endfunction

  // Cycle-by-cycle comparison of every port on both instances.
  always @(negedge c_clk) begin
    if (run)
      for (int s = 0; s < 2; s++)
        for (int p = 0; p < NP; p++)
          chk($sformatf("model sat%0d port%0d {resp,data,tag,busy}", s, p),
              64'(dut_out(s, p)),
              64'({e_resp[s][p], e_data[s][p], e_tag[s][p], m_busy(p)}));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] t);
    cmd_v[4*p +: 4]   = c;
    data_v[32*p +: 32] = a;
    tag_v[2*p +: 2]   = t;
    step();
    cmd_v[4*p +: 4]   = 4'd0;
    data_v[32*p +: 32] = b;
    step();
    data_v[32*p +: 32] = 32'd0;
  endtask

  task automatic lit(input string n, input int s, input int p, input logic [1:0] r,
                     input logic [31:0] d, input logic [1:0] t);
    logic [36:0] o;
    o = dut_out(s, p);
    chk(n, 64'(o[36:1]), 64'({r, d, t}));
  endtask

  bit saw_busy;

  initial begin
    model_clear();
    cmd_v  = '0;
    data_v = '0;
    tag_v  = '0;
    run    = 1'b1;
    repeat (3) @(posedge c_clk);
    #1 reset = 1'b1;

    chk("reset resp", 64'(bus0.out_resp), 64'd0);
    chk("reset data", 64'(bus0.out_data), 64'd0);
    chk("reset tag",  64'(bus0.out_tag),  64'd0);
    chk("reset busy", 64'(bus0.out_busy), 64'd0);
    repeat (3) step();
    chk("idle resp", 64'({bus0.out_resp, bus1.out_resp}), 64'd0);

    // add: result exactly two cycles after the op2 cycle, one cycle wide
    issue(0, 4'd1, 32'h1, 32'h1FFF_FFFF, 2'd2);
    lit("add early", 0, 0, 2'd0, 32'h0, 2'd0);
    step();
    lit("add sat0", 0, 0, 2'd1, 32'h2000_0000, 2'd2);
    lit("add sat1", 1, 0, 2'd1, 32'h2000_0000, 2'd2);
    step();
    lit("add gone", 0, 0, 2'd0, 32'h0, 2'd0);

    issue(0, 4'd2, 32'h10, 32'h3, 2'd1);
    step();
    lit("sub", 0, 0, 2'd1, 32'hD, 2'd1);

    issue(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd0);
    step();
    lit("ovf sat0", 0, 0, 2'd2, 32'h0, 2'd0);
    lit("ovf sat1", 1, 0, 2'd1, 32'hFFFF_FFFF, 2'd0);

    issue(0, 4'd2, 32'h1, 32'hF, 2'd3);
    step();
    lit("unf sat0", 0, 0, 2'd2, 32'h0, 2'd3);
    lit("unf sat1", 1, 0, 2'd1, 32'h0, 2'd3);

    issue(1, 4'd3, 32'h5, 32'h6, 2'd1);
    step();
    lit("cmd3 invalid", 0, 1, 2'd2, 32'h0, 2'd1);
    issue(1, 4'd4, 32'h5, 32'h6, 2'd2);
    step();
    lit("cmd4 invalid", 1, 1, 2'd2, 32'h0, 2'd2);

    issue(2, 4'd5, 32'h1, 32'd33, 2'd0);
    step();
    lit("shl by 33", 0, 2, 2'd1, 32'h2, 2'd0);
    // last grant on port 3 leaves rr at 0 for the arbitration test
    issue(3, 4'd6, 32'h8000_0000, 32'd31, 2'd2);
    step();
    lit("shr by 31", 0, 3, 2'd1, 32'h1, 2'd2);

    // all ports at once: k + k, tag k
    for (int p = 0; p < NP; p++) begin
      cmd_v[4*p +: 4]   = 4'd1;
      data_v[32*p +: 32] = 32'(p);
      tag_v[2*p +: 2]   = 2'(p);
    end
    step();
    cmd_v = '0;
    step();
    data_v = '0;
    for (int p = 0; p < NP; p++) begin
      step();
      lit($sformatf("arb port%0d", p), 0, p, 2'd1, 32'(2 * p), 2'(p));
    end
    step();

    // back-to-back stream on every port, then reset mid-stream
    saw_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int p = 0; p < NP; p++) begin
        cmd_v[4*p +: 4]   = 4'd1 + 4'((c + p) % 2);
        data_v[32*p +: 32] = (c % 7 == 3) ? 32'hFFFF_FFF0 : $urandom_range(0, 1000);
        tag_v[2*p +: 2]   = 2'(c);
      end
      step();
      if (bus0.out_busy != '0) saw_busy = 1'b1;
    end
    chk("busy seen", 64'(saw_busy), 64'd1);

    #2 reset = 1'b0;
    #1;
    chk("async rst resp", 64'({bus0.out_resp, bus1.out_resp}), 64'd0);
    chk("async rst data", 64'(bus0.out_data), 64'd0);
    chk("async rst busy", 64'(bus0.out_busy), 64'd0);
    cmd_v  = '0;
    data_v = '0;
    step();
    step();
    reset = 1'b1;
    repeat (12) step();
    chk("no stale resp", 64'({bus0.out_resp, bus1.out_resp}), 64'd0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
